// File: rtl/audio_sfx_sequencer_pkg.sv
// Purpose: shared constants for the sound-effect sequencer: generator widths, ROM word layout, effect ids, FSM states.
// Latency: n/a (package).
// Backpressure: n/a; ROM word layout is {period, duty, dur, last} with last in bit 0.
package audio_sfx_sequencer_pkg;

  localparam int PERWIDTH = 16;
  // Level of the generator mute input that silences it.
  localparam logic PWM_MUTED = 1'b1;

  localparam int SFX_DURW     = 8;
  localparam int SFX_LAST_OFS = 0;
  localparam int SFX_DUR_OFS  = SFX_LAST_OFS + 1;
  localparam int SFX_DUTY_OFS = SFX_DUR_OFS + SFX_DURW;
  localparam int SFX_PER_OFS  = SFX_DUTY_OFS + PERWIDTH;
  localparam int SFX_WORDW    = SFX_PER_OFS + PERWIDTH;

  localparam int SFX_SHOT = 0;
  localparam int SFX_STEP = 1;
  localparam int SFX_UFO  = 2;
  localparam int SFX_BOOM = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } sfx_state_t;

  // Packs one note into the ROM word layout.
  function automatic logic [SFX_WORDW-1:0] sfx_entry(input int per, input int dty,
                                                     input int dur, input logic last);
    logic [SFX_WORDW-1:0] w;
    w = '0;
    w[SFX_PER_OFS +: PERWIDTH]  = PERWIDTH'(per);
    w[SFX_DUTY_OFS +: PERWIDTH] = PERWIDTH'(dty);
    w[SFX_DUR_OFS +: SFX_DURW]  = SFX_DURW'(dur);
    w[SFX_LAST_OFS]             = last;
    return w;
  endfunction

endpackage

// File: rtl/audio_sfx_sequencer_if.sv
// Purpose: bundle between game logic (trigger pulses), the sequencer and the tone generator inputs.
// Latency: n/a (wires only); master = game/observer side, slave = sequencer.
// Backpressure: none; triggers are fire-and-forget pulses latched by the sequencer.
interface audio_sfx_sequencer_if #(
  parameter int NREQ = 4
);
  import audio_sfx_sequencer_pkg::*;

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]     trig;
  logic [PERWIDTH-1:0] period;
  logic [PERWIDTH-1:0] duty;
  logic                mute;
  logic                busy;
  logic [IDW-1:0]      active_id;

  modport master (output trig, input period, duty, mute, busy, active_id);
  modport slave  (input trig, output period, duty, mute, busy, active_id);

endinterface

// File: rtl/audio_sfx_rom.sv
// Purpose: note table addressed {effect id, step}; ports clk, resetn, addr in, rd_dat out.
// Latency: 1 cycle synchronous read.
// Backpressure: none; a new address may be presented every cycle.
module audio_sfx_rom
  import audio_sfx_sequencer_pkg::*;
#(
  parameter int IDW   = 2,
  parameter int STEPW = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [IDW+STEPW-1:0]   addr,
  output logic [SFX_WORDW-1:0]   rd_dat
);
  localparam int ADDRW = IDW + STEPW;

  function automatic logic [ADDRW-1:0] rom_addr_of(input int id, input int step);
    return ADDRW'((id << STEPW) + step);
  endfunction

  logic [SFX_WORDW-1:0] rd_dat_d, rd_dat_q;

  // Unlisted entries read as all-zero: a rest without last, so an effect
  // running off its table ends at the final step.
  always_comb begin
    rd_dat_d = '0;
    case (addr)
      rom_addr_of(SFX_SHOT, 0): rd_dat_d = sfx_entry(50, 25, 2, 1'b0);
      rom_addr_of(SFX_SHOT, 1): rd_dat_d = sfx_entry(80, 40, 1, 1'b1);
      rom_addr_of(SFX_STEP, 0): rd_dat_d = sfx_entry(60, 30, 1, 1'b0);
      rom_addr_of(SFX_STEP, 1): rd_dat_d = sfx_entry(0, 0, 0, 1'b1);
      rom_addr_of(SFX_UFO,  0): rd_dat_d = sfx_entry(100, 50, 1, 1'b0);
      rom_addr_of(SFX_UFO,  1): rd_dat_d = sfx_entry(120, 60, 2, 1'b1);
      rom_addr_of(SFX_BOOM, 0): rd_dat_d = sfx_entry(200, 100, 1, 1'b1);
      default:                  rd_dat_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rd_dat_q <= '0;
    else         rd_dat_q <= rd_dat_d;
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/audio_sfx_sequencer.sv
// Purpose: latches effect triggers, plays the highest-priority effect's notes into the tone generator.
// Ports: clk, resetn (async active-low), sfx slave (trig in; period, duty, mute, busy, active_id out).
// Latency: trigger latched 1 cycle, selected next cycle, 1 LOAD cycle before each note; no backpressure.
module audio_sfx_sequencer
  import audio_sfx_sequencer_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int STEPW   = 4,
  parameter int TICKDIV = 100000,
  parameter int DURW    = SFX_DURW
) (
  input  logic                 clk,
  input  logic                 resetn,
  audio_sfx_sequencer_if.slave sfx
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PSW = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;

  sfx_state_t          state_q, state_d;
  logic [NREQ-1:0]     pending_q, pending_d;
  logic [IDW-1:0]      active_id_q, active_id_d;
  logic [STEPW-1:0]    step_q, step_d;
  logic [PERWIDTH-1:0] period_q, period_d;
  logic [PERWIDTH-1:0] duty_q, duty_d;
  logic                mute_q, mute_d;
  logic                last_q, last_d;
  logic [DURW-1:0]     dur_q, dur_d;
  logic [PSW-1:0]      presc_q, presc_d;

  logic [IDW+STEPW-1:0] rom_addr;
  logic [SFX_WORDW-1:0] rom_dat;
  logic [PERWIDTH-1:0]  rom_per;
  logic [SFX_DURW-1:0]  rom_dur;
  logic [NREQ-1:0]      clr;
  logic [IDW-1:0]       sel_id;
  logic                 any_pend, take, tick_wrap;

  assign rom_per = rom_dat[SFX_PER_OFS +: PERWIDTH];
  assign rom_dur = rom_dat[SFX_DUR_OFS +: SFX_DURW];

  audio_sfx_rom #(.IDW(IDW), .STEPW(STEPW)) u_rom (
    .clk    (clk),
    .resetn (resetn),
    .addr   (rom_addr),
    .rd_dat (rom_dat)
  );

  // Highest set pending index wins.
  always_comb begin
    sel_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pending_q[i]) sel_id = IDW'(i);
    end
  end

  assign any_pend  = |pending_q;
  assign tick_wrap = (presc_q == PSW'(TICKDIV - 1));
  // While busy, an equal index is a retrigger and restarts through the same path as a preemption.
  assign take      = any_pend && ((state_q == ST_IDLE) || (sel_id >= active_id_q));

  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    step_d      = step_q;
    period_d    = period_q;
    duty_d      = duty_q;
    mute_d      = mute_q;
    last_d      = last_q;
    dur_d       = dur_q;
    presc_d     = presc_q;
    clr         = '0;
    rom_addr    = {active_id_q, step_q};

    if (take) begin
      clr[sel_id] = 1'b1;
      active_id_d = sel_id;
      step_d      = '0;
      rom_addr    = {sel_id, {STEPW{1'b0}}};
      state_d     = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: begin
          // Outputs only change here, so the previous note stays audible through LOAD.
          period_d = rom_per;
          duty_d   = rom_dat[SFX_DUTY_OFS +: PERWIDTH];
          mute_d   = (rom_per == '0) ? PWM_MUTED : ~PWM_MUTED;
          dur_d    = (rom_dur == '0) ? DURW'(1) : DURW'(rom_dur);
          presc_d  = '0;
          last_d   = rom_dat[SFX_LAST_OFS] | (&step_q);
          state_d  = ST_PLAY;
        end
        ST_PLAY: begin
          presc_d = tick_wrap ? '0 : presc_q + PSW'(1);
          if (tick_wrap) begin
            if (dur_q == DURW'(1)) begin
              if (last_q) begin
                mute_d  = PWM_MUTED;
                state_d = ST_IDLE;
              end else begin
                step_d   = step_q + STEPW'(1);
                rom_addr = {active_id_q, step_q + STEPW'(1)};
                state_d  = ST_LOAD;
              end
            end else begin
              dur_d = dur_q - DURW'(1);
            end
          end
        end
        default: ;
      endcase
    end

    // A trigger arriving with its own clear keeps the bit set.
    pending_d = (pending_q & ~clr) | sfx.trig;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      active_id_q <= '0;
      step_q      <= '0;
      period_q    <= '0;
      duty_q      <= '0;
      mute_q      <= PWM_MUTED;
      last_q      <= 1'b0;
      dur_q       <= '0;
      presc_q     <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      active_id_q <= active_id_d;
      step_q      <= step_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      mute_q      <= mute_d;
      last_q      <= last_d;
      dur_q       <= dur_d;
      presc_q     <= presc_d;
    end
  end

  assign sfx.period    = period_q;
  assign sfx.duty      = duty_q;
  assign sfx.mute      = mute_q;
  assign sfx.busy      = (state_q != ST_IDLE);
  assign sfx.active_id = active_id_q;

endmodule
